// File: rtl/usbdev_aon_resume_tx.sv
// Always-on USB remote-wakeup transmitter: waits for a quiet suspended bus, drives K for
// DriveCycles, then releases the bus. All pad controls come straight from flops.
//   state      | meaning
//   IDLE       | no request outstanding, pads released
//   WAIT_IDLE  | request accepted, waiting for IdleCycles of quiet bus
//   DRIVE      | K state driven onto D+/D-
//   RELEASE    | one cycle with pads released before returning to IDLE
module usbdev_aon_resume_tx #(
    parameter int IdleCycles  = 1000,
    parameter int DriveCycles = 400,
    parameter int CntW        = 16
) (
    input  logic clk_aon_i,
    input  logic rst_aon_i,
    input  logic suspend_active_aon_i,
    input  logic bus_not_idle_aon_i,
    input  logic remote_wake_en_aon_i,
    input  logic pinflip_aon_i,
    input  logic resume_req_aon_i,
    output logic usb_dp_o,
    output logic usb_dn_o,
    output logic usb_oe_o,
    output logic resume_busy_o,
    output logic resume_done_o,
    output logic resume_abort_o,
    output logic resume_reject_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_DRIVE     = 2'd2,
        ST_RELEASE   = 2'd3
    } state_e;

    localparam logic [CntW-1:0] IdleMax   = CntW'(IdleCycles);
    localparam logic [CntW-1:0] DriveLoad = CntW'(DriveCycles);

    state_e          r_state, w_state_nxt;
    logic [CntW-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic [CntW-1:0] r_drv_cnt, w_drv_cnt_nxt;
    logic            r_oe, r_dp, r_dn, r_done, r_abort, r_reject;
    logic            w_oe, w_dp, w_dn, w_done, w_abort, w_reject;

    always_comb begin
        w_idle_cnt_nxt = '0;
        if (suspend_active_aon_i && !bus_not_idle_aon_i) begin
            w_idle_cnt_nxt = (r_idle_cnt == IdleMax) ? r_idle_cnt : r_idle_cnt + CntW'(1);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_drv_cnt_nxt = '0;
        w_oe          = 1'b0;
        w_dp          = 1'b0;
        w_dn          = 1'b0;
        w_done        = 1'b0;
        w_abort       = 1'b0;
        w_reject      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (resume_req_aon_i) begin
                    if (remote_wake_en_aon_i && suspend_active_aon_i) begin
                        w_state_nxt = ST_WAIT_IDLE;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (!suspend_active_aon_i || !remote_wake_en_aon_i || bus_not_idle_aon_i) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (r_idle_cnt == IdleMax) begin
                    w_state_nxt   = ST_DRIVE;
                    w_drv_cnt_nxt = DriveLoad;
                    w_oe          = 1'b1;
                    w_dp          = pinflip_aon_i;
                    w_dn          = !pinflip_aon_i;
                end
            end
            ST_DRIVE: begin
                // bus_not_idle is our own K echoing back, so only suspend loss can abort here
                if (!suspend_active_aon_i) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (r_drv_cnt <= CntW'(1)) begin
                    w_state_nxt = ST_RELEASE;
                    w_done      = 1'b1;
                end else begin
                    w_drv_cnt_nxt = r_drv_cnt - CntW'(1);
                    w_oe          = 1'b1;
                    w_dp          = pinflip_aon_i;
                    w_dn          = !pinflip_aon_i;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
        if (rst_aon_i) begin
            r_state    <= ST_IDLE;
            r_idle_cnt <= '0;
            r_drv_cnt  <= '0;
            r_oe       <= 1'b0;
            r_dp       <= 1'b0;
            r_dn       <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_reject   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_drv_cnt  <= w_drv_cnt_nxt;
            r_oe       <= w_oe;
            r_dp       <= w_dp;
            r_dn       <= w_dn;
            r_done     <= w_done;
            r_abort    <= w_abort;
            r_reject   <= w_reject;
        end
    end

    assign usb_oe_o        = r_oe;
    assign usb_dp_o        = r_dp;
    assign usb_dn_o        = r_dn;
    assign resume_busy_o   = (r_state != ST_IDLE);
    assign resume_done_o   = r_done;
    assign resume_abort_o  = r_abort;
    assign resume_reject_o = r_reject;

endmodule

// File: tb/tb_usbdev_aon_resume_tx.sv
// Bench for usbdev_aon_resume_tx: input traces replayed cycle by cycle and compared against an
// event-level model of the resume sequence (accept, quiet-bus wait, K drive, release).
module tb_usbdev_aon_resume_tx;
    localparam int IDLE_N  = 8;
    localparam int DRIVE_N = 4;
    localparam int MAXN    = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic susp = 1'b0, bni = 1'b0, en = 1'b0, flip = 1'b0, req = 1'b0;
    logic dp, dn, oe, busy, done, abort_p, reject;

    usbdev_aon_resume_tx #(.IdleCycles(IDLE_N), .DriveCycles(DRIVE_N), .CntW(16)) dut (
        .clk_aon_i(clk),
        .rst_aon_i(rst),
        .suspend_active_aon_i(susp),
        .bus_not_idle_aon_i(bni),
        .remote_wake_en_aon_i(en),
        .pinflip_aon_i(flip),
        .resume_req_aon_i(req),
        .usb_dp_o(dp),
        .usb_dn_o(dn),
        .usb_oe_o(oe),
        .resume_busy_o(busy),
        .resume_done_o(done),
        .resume_abort_o(abort_p),
        .resume_reject_o(reject)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit t_susp[MAXN], t_bni[MAXN], t_en[MAXN], t_flip[MAXN], t_req[MAXN];
    // bit order: busy, oe, dp, dn, done, abort, reject
    logic [6:0] exp_v[MAXN];
    logic [6:0] obs_v[MAXN];

    task automatic apply_reset();
        rst = 1'b1;
        susp = 1'b0; bni = 1'b0; en = 1'b0; flip = 1'b0; req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_quiet(input int n);
        for (int c = 0; c < n; c++) begin
            t_susp[c] = 1'b1; t_bni[c] = 1'b0; t_en[c] = 1'b1; t_flip[c] = 1'b0; t_req[c] = 1'b0;
        end
    endtask

    task automatic drive_trace(input int n);
        for (int c = 0; c < n; c++) begin
            susp = t_susp[c]; bni = t_bni[c]; en = t_en[c]; flip = t_flip[c]; req = t_req[c];
            @(posedge clk);
            @(negedge clk);
            obs_v[c] = {busy, oe, dp, dn, done, abort_p, reject};
        end
        req = 1'b0;
    endtask

    // Event-level model: out[c] is what the outputs show after the edge that samples inputs[c].
    task automatic model(input int n);
        int run[MAXN];
        int c, k, kind, d, idx;
        bit stop;
        for (int i = 0; i < n; i++) begin
            if (t_susp[i] && !t_bni[i]) run[i] = (i == 0) ? 1 : ((run[i-1] >= IDLE_N) ? IDLE_N : run[i-1] + 1);
            else run[i] = 0;
            exp_v[i] = '0;
        end
        c = 0;
        while (c < n) begin
            if (!t_req[c]) begin
                c++;
            end else if (!(t_en[c] && t_susp[c])) begin
                exp_v[c][0] = 1'b1;
                c++;
            end else begin
                k = c + 1;
                kind = 0;
                while (k < n && kind == 0) begin
                    if (!t_susp[k] || !t_en[k] || t_bni[k]) kind = 1;
                    else if (run[k-1] == IDLE_N) kind = 2;
                    else k++;
                end
                for (int j = c; j < k && j < n; j++) exp_v[j][6] = 1'b1;
                if (kind == 0) begin
                    c = n;
                end else if (kind == 1) begin
                    exp_v[k][1] = 1'b1;
                    c = k + 1;
                end else begin
                    d = k;
                    stop = 1'b0;
                    c = n;
                    for (int i = 0; i <= DRIVE_N && !stop; i++) begin
                        idx = d + i;
                        if (idx >= n) begin
                            stop = 1'b1;
                        end else if (i > 0 && !t_susp[idx]) begin
                            exp_v[idx][1] = 1'b1;
                            c = idx + 1;
                            stop = 1'b1;
                        end else if (i == DRIVE_N) begin
                            exp_v[idx][6] = 1'b1;
                            exp_v[idx][2] = 1'b1;
                            c = idx + 2;
                            stop = 1'b1;
                        end else begin
                            exp_v[idx][6:3] = {1'b1, 1'b1, t_flip[idx], !t_flip[idx]};
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        susp = 1'b1; en = 1'b1; req = 1'b1; flip = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, oe, dp, dn, done, abort_p, reject} !== 7'b0) begin
                failures++;
                $display("FAIL reset_outputs got=%b exp=%b", {busy, oe, dp, dn, done, abort_p, reject}, 7'b0);
            end
        end
        apply_reset();
    endtask

    task automatic test_full_sequence(input bit flip_val);
        int first_oe, oe_cnt;
        apply_reset();
        fill_quiet(24);
        t_bni[0] = 1'b1; t_bni[1] = 1'b1;
        t_req[2] = 1'b1;
        for (int c = 0; c < 24; c++) t_flip[c] = flip_val;
        model(24);
        drive_trace(24);
        first_oe = -1; oe_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL full_seq flip=%0d cycle %0d got=%b exp=%b", flip_val, c, obs_v[c], exp_v[c]);
            end
            if (obs_v[c][5]) begin
                oe_cnt++;
                if (first_oe < 0) first_oe = c;
            end
        end
        checks++;
        // request sampled at cycle 2, eight quiet WAIT_IDLE cycles, K first visible at cycle 10
        if (first_oe !== 10 || oe_cnt !== DRIVE_N) begin
            failures++;
            $display("FAIL full_seq_timing first_oe=%0d oe_cycles=%0d exp first_oe=10 oe_cycles=%0d", first_oe, oe_cnt, DRIVE_N);
        end
    endtask

    task automatic test_reject();
        apply_reset();
        fill_quiet(8);
        t_en[3] = 1'b0;
        t_req[3] = 1'b1;
        model(8);
        drive_trace(8);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL reject cycle %0d got=%b exp=%b", c, obs_v[c], exp_v[c]);
            end
        end
        checks++;
        if (obs_v[3] !== 7'b0000001) begin
            failures++;
            $display("FAIL reject_pulse got=%b exp=%b", obs_v[3], 7'b0000001);
        end
    endtask

    task automatic test_wait_abort();
        apply_reset();
        fill_quiet(16);
        t_bni[0] = 1'b1; t_bni[1] = 1'b1;
        t_req[2] = 1'b1;
        t_bni[7] = 1'b1;
        model(16);
        drive_trace(16);
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL wait_abort cycle %0d got=%b exp=%b", c, obs_v[c], exp_v[c]);
            end
        end
        checks++;
        if (obs_v[7] !== 7'b0000010) begin
            failures++;
            $display("FAIL wait_abort_pulse got=%b exp=%b", obs_v[7], 7'b0000010);
        end
    endtask

    task automatic test_drive_suspend_drop();
        apply_reset();
        fill_quiet(20);
        t_bni[0] = 1'b1; t_bni[1] = 1'b1;
        t_req[2] = 1'b1;
        t_susp[12] = 1'b0;
        model(20);
        drive_trace(20);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL drive_abort cycle %0d got=%b exp=%b", c, obs_v[c], exp_v[c]);
            end
        end
        checks++;
        if (obs_v[11][5] !== 1'b1 || obs_v[12] !== 7'b0000010) begin
            failures++;
            $display("FAIL drive_abort_edge got oe11=%b out12=%b exp oe11=1 out12=0000010", obs_v[11][5], obs_v[12]);
        end
    endtask

    task automatic test_reset_mid_drive();
        apply_reset();
        fill_quiet(13);
        t_bni[0] = 1'b1; t_bni[1] = 1'b1;
        t_req[2] = 1'b1;
        model(13);
        drive_trace(13);
        for (int c = 0; c < 13; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL pre_reset cycle %0d got=%b exp=%b", c, obs_v[c], exp_v[c]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, oe, dp, dn, done, abort_p, reject} !== 7'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", {busy, oe, dp, dn, done, abort_p, reject}, 7'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        fill_quiet(20);
        t_bni[0] = 1'b1; t_bni[1] = 1'b1;
        t_req[2] = 1'b1;
        model(20);
        drive_trace(20);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL post_reset cycle %0d got=%b exp=%b", c, obs_v[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        n = 200;
        for (int t = 0; t < 6; t++) begin
            apply_reset();
            for (int c = 0; c < n; c++) begin
                t_susp[c] = ($urandom_range(99) < 96);
                t_bni[c]  = ($urandom_range(99) < 4);
                t_en[c]   = ($urandom_range(99) < 95);
                t_flip[c] = ($urandom_range(99) < 50);
                t_req[c]  = ($urandom_range(99) < 10);
            end
            model(n);
            drive_trace(n);
            for (int c = 0; c < n; c++) begin
                checks++;
                if (obs_v[c] !== exp_v[c]) begin
                    failures++;
                    $display("FAIL random trace %0d cycle %0d got=%b exp=%b", t, c, obs_v[c], exp_v[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence(1'b0);
        test_reject();
        test_wait_abort();
        test_full_sequence(1'b1);
        test_drive_suspend_drop();
        test_reset_mid_drive();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usbdev_aon_resume_tx.md
USBDEV_AON_RESUME_TX -- requirements
Module: usbdev_aon_resume_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk_aon_i and rst_aon_i.
REQ-002 Parameter IdleCycles, default 1000, SHALL set the minimum continuous idle-bus time before resume may be driven (5 ms at 200 kHz).
REQ-003 Parameter DriveCycles, default 400, SHALL set the K-state drive duration (2 ms at 200 kHz); legal range 1..65535.
REQ-004 Parameter CntW, default 16, SHALL set the width of the idle and drive counters.
REQ-005 Ports SHALL be:
- clk_aon_i  in  1  AON clock (~200 kHz)
- rst_aon_i  in  1  async reset, active high
- suspend_active_aon_i  in  1  AON wake detector owns the bus
- bus_not_idle_aon_i  in  1  host activity seen, filtered
- remote_wake_en_aon_i  in  1  host has enabled remote wakeup
- pinflip_aon_i  in  1  D+/D- swapped at the pins
- resume_req_aon_i  in  1  single-cycle request from IP, already AON-synchronized
- usb_dp_o  out  1  D+ drive value
- usb_dn_o  out  1  D- drive value
- usb_oe_o  out  1  output enable for D+/D-
- resume_busy_o  out  1  request accepted, not yet finished
- resume_done_o  out  1  single-cycle pulse, drive completed
- resume_abort_o  out  1  single-cycle pulse, accepted request abandoned
- resume_reject_o  out  1  single-cycle pulse, request refused

Function
REQ-006 The idle counter SHALL increment each cycle while suspend_active_aon_i=1 and bus_not_idle_aon_i=0, saturate at IdleCycles, and clear to 0 in any other cycle.
REQ-007 The FSM SHALL have states IDLE, WAIT_IDLE, DRIVE, RELEASE, held in a registered state variable.
REQ-008 In IDLE, resume_req_aon_i=1 with remote_wake_en_aon_i=1 and suspend_active_aon_i=1 SHALL move to WAIT_IDLE next cycle.
REQ-009 In IDLE, resume_req_aon_i=1 with either enable low SHALL leave the state in IDLE and pulse resume_reject_o in the next cycle.
REQ-010 resume_req_aon_i in any state other than IDLE SHALL be ignored, with no reject pulse and no queuing.
REQ-011 In WAIT_IDLE, suspend_active_aon_i=0, remote_wake_en_aon_i=0 or bus_not_idle_aon_i=1 SHALL return to IDLE and pulse resume_abort_o; abort SHALL take priority over entering DRIVE in the same cycle.
REQ-012 In WAIT_IDLE, idle counter == IdleCycles SHALL move to DRIVE and load the drive counter with DriveCycles.
REQ-013 In DRIVE, usb_oe_o SHALL be 1 and the outputs SHALL present K: usb_dp_o=0, usb_dn_o=1 when pinflip_aon_i=0; usb_dp_o=1, usb_dn_o=0 when pinflip_aon_i=1.
REQ-014 In DRIVE, the drive counter SHALL decrement each cycle; when it reads 1, the FSM SHALL move to RELEASE, giving exactly DriveCycles cycles with usb_oe_o=1.
REQ-015 In DRIVE, bus_not_idle_aon_i SHALL be ignored, because it reflects the block's own K.
REQ-016 In DRIVE, suspend_active_aon_i=0 SHALL move to IDLE next cycle, deassert usb_oe_o and pulse resume_abort_o.
REQ-017 RELEASE SHALL last one cycle with usb_oe_o=0 and usb_dp_o=usb_dn_o=0, pulse resume_done_o, then return to IDLE.
REQ-018 usb_oe_o, usb_dp_o and usb_dn_o SHALL be driven from flops, and usb_oe_o SHALL never glitch.
REQ-019 resume_busy_o SHALL be 1 exactly in WAIT_IDLE, DRIVE and RELEASE.
REQ-020 resume_done_o, resume_abort_o and resume_reject_o SHALL be mutually exclusive in every cycle.
REQ-021 The block SHALL sample pinflip_aon_i every DRIVE cycle; a mid-drive change SHALL take effect on the next cycle.
REQ-022 An unreachable state encoding SHALL return to IDLE with usb_oe_o=0.

Reset
REQ-023 While rst_aon_i=1, the state SHALL be IDLE, both counters 0, and all outputs 0, independent of the clock.
REQ-024 Reset asserted mid-DRIVE SHALL deassert usb_oe_o immediately and asynchronously, with no done or abort pulse.

Verification (IdleCycles=8, DriveCycles=4)
REQ-025 Req with en=1 and suspend=1, bus idle throughout -> busy=1; 8 idle cycles, then oe=1, dp=0, dn=1 for exactly 4 cycles; done pulse; busy=0.
REQ-026 Req with remote_wake_en_aon_i=0 -> resume_reject_o=1 for 1 cycle, oe stays 0, busy stays 0.
REQ-027 Req accepted, bus_not_idle_aon_i=1 on the 5th WAIT_IDLE cycle -> abort pulse, IDLE, oe never 1.
REQ-028 pinflip_aon_i=1, full sequence -> dp=1, dn=0 during the 4 DRIVE cycles.
REQ-029 suspend_active_aon_i drops on the 2nd DRIVE cycle -> oe=0 next cycle, abort pulse, no done pulse.
REQ-030 rst_aon_i asserted on the 3rd DRIVE cycle -> oe=0 without a clock edge; after release, state IDLE and counters 0.
